// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths and response payload type for the mem pipeline
//
// Contents:
//   ADDR_WIDTH, DATA_WIDTH, MASK_WIDTH, ID_WIDTH : request/response field widths
//   RESP_DEPTH                                    : response buffer depth (credits)
//   mem_t                                         : response payload struct
package mem_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int MASK_WIDTH = DATA_WIDTH / 8;
    localparam int ID_WIDTH   = 4;
    localparam int RESP_DEPTH = 3;

    typedef struct packed {
        logic                  read_enable;
        logic [MASK_WIDTH-1:0] write_enable;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [ID_WIDTH-1:0]   id;
    } mem_t;

endpackage

// File: rtl/std_mem_intf.sv
// rtl/std_mem_intf.sv - valid/ready memory request/response stream
//
// Signals: valid, ready, read_enable, write_enable[MASK_WIDTH], addr, data, id.
// Modports: in  (consumer: samples payload, drives ready)
//           out (producer: drives payload, samples ready)
// Widths come from mem_pkg, so every instance (request and response side)
// has identical field widths by construction.
interface std_mem_intf;
    import mem_pkg::*;

    logic                  valid;
    logic                  ready;
    logic                  read_enable;
    logic [MASK_WIDTH-1:0] write_enable;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [ID_WIDTH-1:0]   id;

    modport in  (input  valid, read_enable, write_enable, addr, data, id, output ready);
    modport out (output valid, read_enable, write_enable, addr, data, id, input  ready);

endinterface

// File: rtl/mem_sram_resp_buffer.sv
// rtl/mem_sram_resp_buffer.sv - RESP_DEPTH-entry synchronous FIFO of response payloads
//
// Ports:
//   clk, rst     : clock, synchronous active-low reset
//   i_push       : write i_push_data at the tail this edge
//   i_push_data  : payload to store
//   i_pop        : drop the head entry this edge (ignored when empty)
//   o_count      : number of stored entries (0..RESP_DEPTH)
//   o_head       : head payload (valid when o_count != 0)
module mem_sram_resp_buffer
    import mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  mem_t       i_push_data,
    input  logic       i_pop,
    output logic [1:0] o_count,
    output mem_t       o_head
);

    localparam logic [1:0] LAST_IDX = 2'(RESP_DEPTH - 1);
    localparam logic [1:0] FULL_CNT = 2'(RESP_DEPTH);

    mem_t       r_entries [RESP_DEPTH];
    logic [1:0] r_wr_ptr;
    logic [1:0] r_rd_ptr;
    logic [1:0] r_count;
    logic       w_do_push;
    logic       w_do_pop;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == LAST_IDX) ? 2'd0 : p + 2'd1;
    endfunction

    assign w_do_pop  = i_pop && (r_count != 2'd0);
    // A push into a full buffer is only legal when the head leaves the same edge.
    assign w_do_push = i_push && ((r_count != FULL_CNT) || w_do_pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            if (w_do_push && !w_do_pop)      r_count <= r_count + 2'd1;
            else if (!w_do_push && w_do_pop) r_count <= r_count - 2'd1;
        end
    end

    // Storage needs no reset: the count gates every read of it.
    always_ff @(posedge clk) begin
        if (w_do_push) r_entries[r_wr_ptr] <= i_push_data;
    end

    assign o_count = r_count;
    assign o_head  = r_entries[r_rd_ptr];

endmodule

// File: rtl/mem_sram_port.sv
// rtl/mem_sram_port.sv - terminal mem stage: single-port SRAM with tagged, credited responses
//
// Parameters:
//   DEPTH         : words in the array (power of two, >= 2); index = addr[$clog2(DEPTH)-1:0]
//   WRITE_RESPOND : 1 = accepted writes also produce a response
// Ports:
//   clk, rst      : clock, synchronous active-low reset
//   mem_in        : request stream (ready is a registered credit check)
//   mem_out       : response stream, strictly in request order
//   stat_reads, stat_writes, stat_stalls : 32-bit counters, present only
//                   when MEM_SRAM_PORT_STATS_EN is defined
module mem_sram_port
    import mem_pkg::*;
#(
    parameter int DEPTH         = 1024,
    parameter int WRITE_RESPOND = 0
) (
    input  logic        clk,
    input  logic        rst,
    std_mem_intf.in     mem_in,
    std_mem_intf.out    mem_out
`ifdef MEM_SRAM_PORT_STATS_EN
    ,
    output logic [31:0] stat_reads,
    output logic [31:0] stat_writes,
    output logic [31:0] stat_stalls
`endif
);

    localparam int IDX_WIDTH = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  r_ready;
    logic                  r_inflight;
    mem_t                  r_resp;

    logic                  w_accept;
    logic                  w_gen_resp;
    logic                  w_pop;
    logic                  w_inflight_next;
    logic [1:0]            w_count;
    logic [1:0]            w_count_next;
    logic [IDX_WIDTH-1:0]  w_idx;
    mem_t                  w_head;

    assign w_accept        = mem_in.valid && r_ready;
    assign w_idx           = mem_in.addr[IDX_WIDTH-1:0];
    assign w_gen_resp      = mem_in.read_enable
                           || ((|mem_in.write_enable) && (WRITE_RESPOND != 0));
    assign w_inflight_next = w_accept && w_gen_resp;
    assign w_pop           = (w_count != 2'd0) && mem_out.ready;

    // Buffer occupancy after this edge: the in-flight response lands, the head may leave.
    always_comb begin
        w_count_next = w_count;
        if (r_inflight && !w_pop)      w_count_next = w_count + 2'd1;
        else if (!r_inflight && w_pop) w_count_next = w_count - 2'd1;
    end

    // Credits: ready for the next cycle only if one more response still fits
    // alongside everything in flight or buffered after this edge. Keeps ready
    // a flop with no path from mem_out.ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ready    <= 1'b0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_inflight_next;
            r_ready    <= ({1'b0, w_count_next} + {2'b00, w_inflight_next}) < 3'(RESP_DEPTH);
        end
    end

    // Byte-lane writes; array contents survive reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < MASK_WIDTH; i++) begin
                if (mem_in.write_enable[i]) r_mem[w_idx][8*i +: 8] <= mem_in.data[8*i +: 8];
            end
        end
    end

    // Read-first: the nonblocking write above lands after this read samples the old word.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_resp.read_enable  <= mem_in.read_enable;
            r_resp.write_enable <= mem_in.write_enable;
            r_resp.addr         <= mem_in.addr;
            r_resp.id           <= mem_in.id;
            r_resp.data         <= mem_in.read_enable ? r_mem[w_idx] : '0;
        end
    end

    mem_sram_resp_buffer u_resp_buffer (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_inflight),
        .i_push_data (r_resp),
        .i_pop       (w_pop),
        .o_count     (w_count),
        .o_head      (w_head)
    );

    assign mem_in.ready         = r_ready;
    assign mem_out.valid        = (w_count != 2'd0);
    assign mem_out.read_enable  = w_head.read_enable;
    assign mem_out.write_enable = w_head.write_enable;
    assign mem_out.addr         = w_head.addr;
    assign mem_out.data         = w_head.data;
    assign mem_out.id           = w_head.id;

`ifdef MEM_SRAM_PORT_STATS_EN
    logic [31:0] r_stat_reads;
    logic [31:0] r_stat_writes;
    logic [31:0] r_stat_stalls;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stat_reads  <= '0;
            r_stat_writes <= '0;
            r_stat_stalls <= '0;
        end else begin
            if (w_accept && mem_in.read_enable)  r_stat_reads  <= r_stat_reads + 32'd1;
            if (w_accept && |mem_in.write_enable) r_stat_writes <= r_stat_writes + 32'd1;
            if ((w_count != 2'd0) && !mem_out.ready) r_stat_stalls <= r_stat_stalls + 32'd1;
        end
    end

    assign stat_reads  = r_stat_reads;
    assign stat_writes = r_stat_writes;
    assign stat_stalls = r_stat_stalls;
`endif

endmodule

// File: tb/tb_mem_sram_port.sv
// tb/tb_mem_sram_port.sv - directed self-checking bench for mem_sram_port
module tb_mem_sram_port;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    std_mem_intf in_if ();
    std_mem_intf out_if ();

`ifdef MEM_SRAM_PORT_STATS_EN
    logic [31:0] stat_reads;
    logic [31:0] stat_writes;
    logic [31:0] stat_stalls;
`endif

    mem_sram_port #(.DEPTH(1024), .WRITE_RESPOND(0)) dut (
        .clk     (clk),
        .rst     (rst),
        .mem_in  (in_if),
        .mem_out (out_if)
`ifdef MEM_SRAM_PORT_STATS_EN
        ,
        .stat_reads  (stat_reads),
        .stat_writes (stat_writes),
        .stat_stalls (stat_stalls)
`endif
    );

    int   n_checks = 0;
    int   n_fails  = 0;
    int   cyc      = 0;
    mem_t rsp_q [$];
    int   rsp_cyc [$];
    mem_t mon_r;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes are decided by values that are stable from #1 after an edge,
    // so observing them on the falling edge records exactly what the next edge pops.
    always @(negedge clk) begin
        if (rst && out_if.valid && out_if.ready) begin
            mon_r.read_enable  = out_if.read_enable;
            mon_r.write_enable = out_if.write_enable;
            mon_r.addr         = out_if.addr;
            mon_r.data         = out_if.data;
            mon_r.id           = out_if.id;
            rsp_q.push_back(mon_r);
            rsp_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_if.valid        = 1'b0;
        in_if.read_enable  = 1'b0;
        in_if.write_enable = '0;
        in_if.addr         = '0;
        in_if.data         = '0;
        in_if.id           = '0;
    endtask

    task automatic drive(input logic rd, input logic [3:0] we, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] id);
        in_if.valid        = 1'b1;
        in_if.read_enable  = rd;
        in_if.write_enable = we;
        in_if.addr         = addr;
        in_if.data         = data;
        in_if.id           = id;
    endtask

    // Returns #1 after the accepting edge.
    task automatic send(input logic rd, input logic [3:0] we, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] id);
        int g = 0;
        drive(rd, we, addr, data, id);
        while (!in_if.ready && g < 50) begin
            tick();
            g++;
        end
        if (!in_if.ready) check("send_ready_timeout", 64'(in_if.ready), 64'd1);
        tick();
        idle();
    endtask

    task automatic wait_resp(input string tag, input int n);
        int g = 0;
        while (rsp_q.size() < n && g < 60) begin
            tick();
            g++;
        end
        check(tag, 64'(rsp_q.size()), 64'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc;
        int drops;
        idle();
        out_if.ready = 1'b1;

        // Reset state
        tick(); tick(); tick();
        check("rst_out_valid", 64'(out_if.valid), 64'd0);
        check("rst_in_ready", 64'(in_if.ready), 64'd0);
        rst = 1'b1;
        tick();
        check("ready_after_rst", 64'(in_if.ready), 64'd1);

        // Write then read, latency 1, no write response
        send(1'b0, 4'hF, 32'h10, 32'hDEADBEEF, 4'd1);
        tick(); tick(); tick();
        check("no_write_resp", 64'(rsp_q.size()), 64'd0);
        send(1'b1, 4'h0, 32'h10, 32'h0, 4'd5);
        check("rd_lat_before", 64'(out_if.valid), 64'd0);
        tick();
        check("rd_lat_valid", 64'(out_if.valid), 64'd1);
        check("rd_data", 64'(out_if.data), 64'hDEADBEEF);
        check("rd_id", 64'(out_if.id), 64'd5);
        tick(); tick();
        check("rd_one_resp", 64'(rsp_q.size()), 64'd1);

        // Byte mask, read-first, aliasing
        rsp_q.delete(); rsp_cyc.delete();
        send(1'b0, 4'hF, 32'h4, 32'h11223344, 4'd0);
        send(1'b1, 4'b0101, 32'h4, 32'hAABBCCDD, 4'd6);
        send(1'b1, 4'h0, 32'h4, 32'h0, 4'd7);
        send(1'b1, 4'h0, 32'h404, 32'h0, 4'd8);
        wait_resp("mask_resp_count", 3);
        if (rsp_q.size() >= 3) begin
            check("rmw_old_data", 64'(rsp_q[0].data), 64'h11223344);
            check("rmw_id", 64'(rsp_q[0].id), 64'd6);
            check("rmw_we_copy", 64'(rsp_q[0].write_enable), 64'h5);
            check("mask_new_data", 64'(rsp_q[1].data), 64'h11BB33DD);
            check("alias_data", 64'(rsp_q[2].data), 64'h11BB33DD);
            check("alias_addr", 64'(rsp_q[2].addr), 64'h404);
        end

        // Throughput: 16 back-to-back reads
        for (int i = 0; i < 16; i++) send(1'b0, 4'hF, 32'h100 + i, 32'hA5000000 | i, 4'd0);
        rsp_q.delete(); rsp_cyc.delete();
        drops = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4'h0, 32'h100 + i, 32'h0, i[3:0]);
            if (!in_if.ready) drops++;
            tick();
        end
        idle();
        wait_resp("thru_count", 16);
        check("thru_ready_drops", 64'(drops), 64'd0);
        if (rsp_q.size() >= 16) begin
            for (int i = 0; i < 16; i++) begin
                check("thru_id", 64'(rsp_q[i].id), 64'(i % 16));
                check("thru_data", 64'(rsp_q[i].data), 64'(32'hA5000000 | i));
                check("thru_cycle", 64'(rsp_cyc[i] - rsp_cyc[0]), 64'(i));
            end
        end

        // Backpressure: exactly 3 credits, stable head, ordered drain
        rsp_q.delete(); rsp_cyc.delete();
        out_if.ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 4'h0, 32'h100 + acc, 32'h0, acc[3:0]);
            if (in_if.ready) acc++;
            tick();
        end
        check("bp_accepted", 64'(acc), 64'd3);
        check("bp_ready_low", 64'(in_if.ready), 64'd0);
        check("bp_valid", 64'(out_if.valid), 64'd1);
        check("bp_head_id", 64'(out_if.id), 64'd0);
        check("bp_head_data", 64'(out_if.data), 64'hA5000000);
        out_if.ready = 1'b1;
        for (int c = 0; c < 40 && acc < 6; c++) begin
            drive(1'b1, 4'h0, 32'h100 + acc, 32'h0, acc[3:0]);
            if (in_if.ready) acc++;
            tick();
        end
        idle();
        check("bp_resumed", 64'(acc), 64'd6);
        wait_resp("bp_count", 6);
        if (rsp_q.size() >= 6) begin
            for (int i = 0; i < 6; i++) check("bp_order", 64'(rsp_q[i].id), 64'(i));
        end

        // Reset mid-stream
        rsp_q.delete(); rsp_cyc.delete();
        out_if.ready = 1'b0;
        send(1'b1, 4'h0, 32'h10, 32'h0, 4'd1);
        send(1'b1, 4'h0, 32'h10, 32'h0, 4'd2);
        tick();
        check("mid_valid_before", 64'(out_if.valid), 64'd1);
        rst = 1'b0;
        tick();
        check("mid_rst_valid", 64'(out_if.valid), 64'd0);
        check("mid_rst_ready", 64'(in_if.ready), 64'd0);
        rst = 1'b1;
        tick();
        check("mid_ready_back", 64'(in_if.ready), 64'd1);
        out_if.ready = 1'b1;
        send(1'b1, 4'h0, 32'h10, 32'h0, 4'd3);
        wait_resp("mid_resp_count", 1);
        tick(); tick();
        check("mid_no_stale", 64'(rsp_q.size()), 64'd1);
        if (rsp_q.size() >= 1) begin
            check("mid_kept_data", 64'(rsp_q[0].data), 64'hDEADBEEF);
            check("mid_kept_id", 64'(rsp_q[0].id), 64'd3);
        end

`ifdef MEM_SRAM_PORT_STATS_EN
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rsp_q.delete(); rsp_cyc.delete();
        for (int i = 0; i < 3; i++) send(1'b0, 4'hF, 32'h20 + i, 32'h0, 4'd0);
        for (int i = 0; i < 3; i++) send(1'b1, 4'h0, 32'h20 + i, 32'h0, 4'd0);
        wait_resp("stat_resp_count", 3);
        tick();
        out_if.ready = 1'b0;
        send(1'b1, 4'h0, 32'h20, 32'h0, 4'd0);
        tick();
        tick();
        tick();
        out_if.ready = 1'b1;
        tick();
        check("stat_reads", 64'(stat_reads), 64'd4);
        check("stat_writes", 64'(stat_writes), 64'd3);
        check("stat_stalls", 64'(stat_stalls), 64'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
